// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared LPC record layout, cycle-type codes and channel config type
package lpc_pkg;

    localparam int REC_W    = 48;
    localparam int ADDR_LSB = 16;
    localparam int ADDR_W   = 32;
    localparam int DATA_LSB = 8;
    localparam int DATA_W   = 8;
    localparam int CYC_LSB  = 0;
    localparam int CYC_W    = 4;

    localparam logic [CYC_W-1:0] CYC_IO_READ   = 4'b0000;
    localparam logic [CYC_W-1:0] CYC_IO_WRITE  = 4'b0010;
    localparam logic [CYC_W-1:0] CYC_MEM_READ  = 4'b0100;
    localparam logic [CYC_W-1:0] CYC_MEM_WRITE = 4'b0110;

    localparam logic [4:0] DROP_CNT_SEL = 5'd31;

    typedef struct packed {
        logic              enable;
        logic              drop;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] addr_mask;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] data_mask;
        logic [CYC_W-1:0]  cyc;
        logic [CYC_W-1:0]  cyc_mask;
    } chan_cfg_t;

    // The reserved zero nibble [7:4] is left 0 so it never takes part in a compare.
    function automatic logic [REC_W-1:0] rec_pack(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data,
        input logic [CYC_W-1:0]  cyc
    );
        logic [REC_W-1:0] r;
        r = '0;
        r[ADDR_LSB +: ADDR_W] = addr;
        r[DATA_LSB +: DATA_W] = data;
        r[CYC_LSB  +: CYC_W]  = cyc;
        return r;
    endfunction

endpackage

// File: rtl/lpc_match_channel.sv
// rtl/lpc_match_channel.sv - one match channel: config registers, masked comparator, LED stretcher
module lpc_match_channel
    import lpc_pkg::*;
#(
    parameter int LED_STRETCH = 3_300_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_write_i,
    input  chan_cfg_t        cfg_i,
    input  logic [REC_W-1:0] rec_i,
    input  logic             hit_i,
    output logic             match_o,
    output logic             drop_o,
    output logic             led_o
);

    localparam int               LED_W      = $clog2(LED_STRETCH + 1);
    localparam logic [LED_W-1:0] LED_RELOAD = LED_W'(LED_STRETCH);

    chan_cfg_t        cfg_q;
    logic [LED_W-1:0] led_cnt_q;
    logic [LED_W-1:0] led_cnt_d;
    logic [REC_W-1:0] cmp_value;
    logic [REC_W-1:0] cmp_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_q <= '0;
        end else if (cfg_write_i) begin
            cfg_q <= cfg_i;
        end
    end

    always_comb begin
        cmp_value = rec_pack(cfg_q.addr, cfg_q.data, cfg_q.cyc);
        cmp_mask  = rec_pack(cfg_q.addr_mask, cfg_q.data_mask, cfg_q.cyc_mask);
        match_o   = cfg_q.enable && (((rec_i ^ cmp_value) & cmp_mask) == '0);
    end

    assign drop_o = cfg_q.drop;

    // A retrigger reloads the full on-time rather than extending the remainder.
    always_comb begin
        led_cnt_d = led_cnt_q;
        if (hit_i) begin
            led_cnt_d = LED_RELOAD;
        end else if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - LED_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_cnt_q <= '0;
        end else begin
            led_cnt_q <= led_cnt_d;
        end
    end

    assign led_o = (led_cnt_q != '0);

endmodule

// File: rtl/lpc_filter_trigger.sv
// rtl/lpc_filter_trigger.sv - N-channel LPC record filter with hit/drop counters and trigger LEDs
module lpc_filter_trigger
    import lpc_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int LED_STRETCH = 3_300_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REC_W-1:0]    input_data,
    input  logic                input_enable,
    output logic [REC_W-1:0]    output_data,
    output logic                output_enable,
    input  logic                cfg_write,
    input  logic [3:0]          cfg_channel,
    input  logic                cfg_enable,
    input  logic                cfg_drop,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [ADDR_W-1:0]   cfg_addr_mask,
    input  logic [DATA_W-1:0]   cfg_data,
    input  logic [DATA_W-1:0]   cfg_data_mask,
    input  logic [CYC_W-1:0]    cfg_cyc,
    input  logic [CYC_W-1:0]    cfg_cyc_mask,
    input  logic                default_pass,
    input  logic                cnt_clear,
    input  logic [4:0]          cnt_sel,
    output logic [CNT_W-1:0]    cnt_value,
    output logic [CHANNELS-1:0] trigger_led
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chan_cfg_t           cfg_in;
    logic [CHANNELS-1:0] match_vec;
    logic [CHANNELS-1:0] drop_vec;

    logic                s1_valid_q;
    logic [REC_W-1:0]    s1_rec_q;
    logic [CHANNELS-1:0] s1_match_q;
    logic [CHANNELS-1:0] s1_drop_q;

    logic [CHANNELS-1:0] win_d;
    logic                win_any;
    logic                pass_d;
    logic                drop_ev;

    logic                out_en_q;
    logic [REC_W-1:0]    out_data_q;
    logic [CHANNELS-1:0] hit_q;

    logic [CNT_W-1:0]    hit_cnt_q [CHANNELS];
    logic [CNT_W-1:0]    drop_cnt_q;
    logic [CNT_W-1:0]    cnt_value_d;
    logic [CNT_W-1:0]    cnt_value_q;

    always_comb begin
        cfg_in           = '0;
        cfg_in.enable    = cfg_enable;
        cfg_in.drop      = cfg_drop;
        cfg_in.addr      = cfg_addr;
        cfg_in.addr_mask = cfg_addr_mask;
        cfg_in.data      = cfg_data;
        cfg_in.data_mask = cfg_data_mask;
        cfg_in.cyc       = cfg_cyc;
        cfg_in.cyc_mask  = cfg_cyc_mask;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        lpc_match_channel #(
            .LED_STRETCH(LED_STRETCH)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .cfg_write_i(cfg_write && (cfg_channel == 4'(c))),
            .cfg_i      (cfg_in),
            .rec_i      (input_data),
            .hit_i      (hit_q[c]),
            .match_o    (match_vec[c]),
            .drop_o     (drop_vec[c]),
            .led_o      (trigger_led[c])
        );
    end

    // Drop modes are captured with the match so a same-cycle config write cannot leak into this record.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_rec_q   <= '0;
            s1_match_q <= '0;
            s1_drop_q  <= '0;
        end else begin
            s1_valid_q <= input_enable;
            if (input_enable) begin
                s1_rec_q   <= input_data;
                s1_match_q <= match_vec;
                s1_drop_q  <= drop_vec;
            end
        end
    end

    always_comb begin
        win_d   = '0;
        win_any = 1'b0;
        pass_d  = default_pass;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!win_any && s1_match_q[c]) begin
                win_d[c] = 1'b1;
                win_any  = 1'b1;
                pass_d   = !s1_drop_q[c];
            end
        end
        if (!s1_valid_q) begin
            win_d  = '0;
            pass_d = 1'b0;
        end
        drop_ev = s1_valid_q && !pass_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_en_q   <= 1'b0;
            out_data_q <= '0;
            hit_q      <= '0;
        end else begin
            out_en_q <= pass_d;
            hit_q    <= win_d;
            if (pass_d) begin
                out_data_q <= s1_rec_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || cnt_clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                hit_cnt_q[c] <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (win_d[c] && (hit_cnt_q[c] != CNT_MAX)) begin
                    hit_cnt_q[c] <= hit_cnt_q[c] + CNT_W'(1);
                end
            end
            if (drop_ev && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_value_d = '0;
        if (cnt_sel == DROP_CNT_SEL) begin
            cnt_value_d = drop_cnt_q;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (cnt_sel == 5'(c)) begin
                cnt_value_d = hit_cnt_q[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_value_q <= '0;
        end else begin
            cnt_value_q <= cnt_value_d;
        end
    end

    assign output_enable = out_en_q;
    assign output_data   = out_data_q;
    assign cnt_value     = cnt_value_q;

endmodule

// File: tb/tb_lpc_filter_trigger.sv
// tb/tb_lpc_filter_trigger.sv - self-checking bench for lpc_filter_trigger
module tb_lpc_filter_trigger;

    localparam int CH   = 4;
    localparam int CW   = 4;
    localparam int LS   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [47:0]   input_data = '0;
    logic          input_enable = 1'b0;
    logic [47:0]   output_data;
    logic          output_enable;
    logic          cfg_write = 1'b0;
    logic [3:0]    cfg_channel = '0;
    logic          cfg_enable = 1'b0;
    logic          cfg_drop = 1'b0;
    logic [31:0]   cfg_addr = '0;
    logic [31:0]   cfg_addr_mask = '0;
    logic [7:0]    cfg_data = '0;
    logic [7:0]    cfg_data_mask = '0;
    logic [3:0]    cfg_cyc = '0;
    logic [3:0]    cfg_cyc_mask = '0;
    logic          default_pass = 1'b1;
    logic          cnt_clear = 1'b0;
    logic [4:0]    cnt_sel = '0;
    logic [CW-1:0] cnt_value;
    logic [CH-1:0] trigger_led;

    always #5 clock = ~clock;

    lpc_filter_trigger #(
        .CHANNELS   (CH),
        .CNT_W      (CW),
        .LED_STRETCH(LS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .input_data   (input_data),
        .input_enable (input_enable),
        .output_data  (output_data),
        .output_enable(output_enable),
        .cfg_write    (cfg_write),
        .cfg_channel  (cfg_channel),
        .cfg_enable   (cfg_enable),
        .cfg_drop     (cfg_drop),
        .cfg_addr     (cfg_addr),
        .cfg_addr_mask(cfg_addr_mask),
        .cfg_data     (cfg_data),
        .cfg_data_mask(cfg_data_mask),
        .cfg_cyc      (cfg_cyc),
        .cfg_cyc_mask (cfg_cyc_mask),
        .default_pass (default_pass),
        .cnt_clear    (cnt_clear),
        .cnt_sel      (cnt_sel),
        .cnt_value    (cnt_value),
        .trigger_led  (trigger_led)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: channel table, counters, LED timers and the record awaiting its decision.
    bit          m_en [CH];
    bit          m_dr [CH];
    logic [31:0] m_addr [CH];
    logic [31:0] m_am [CH];
    logic [7:0]  m_data [CH];
    logic [7:0]  m_dm [CH];
    logic [3:0]  m_cyc [CH];
    logic [3:0]  m_cm [CH];
    int          m_hit [CH];
    int          m_dropc;
    int          m_led [CH];
    bit          p_valid;
    logic [47:0] p_rec;
    int          p_win;
    bit          p_wdrop;
    int          w_reg;

    localparam logic [47:0] REC_A = 48'h0000_0080_3402;
    localparam logic [47:0] REC_B = 48'h0000_0081_0002;
    localparam logic [47:0] REC_C = 48'h0000_0090_5502;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_dr[c] = 0; m_addr[c] = '0; m_am[c] = '0;
            m_data[c] = '0; m_dm[c] = '0; m_cyc[c] = '0; m_cm[c] = '0;
            m_hit[c] = 0; m_led[c] = 0;
        end
        m_dropc = 0; p_valid = 0; p_rec = '0; p_win = -1; p_wdrop = 0; w_reg = -1;
    endtask

    function automatic int decide(input logic [47:0] r);
        for (int c = 0; c < CH; c++) begin
            if (m_en[c] && (((r[47:16] ^ m_addr[c]) & m_am[c]) == 0)
                        && (((r[15:8] ^ m_data[c]) & m_dm[c]) == 0)
                        && (((r[3:0] ^ m_cyc[c]) & m_cm[c]) == 0))
                return c;
        end
        return -1;
    endfunction

    function automatic int sel_model(input logic [4:0] s);
        if (s == 5'd31) return m_dropc;
        if (s < CH) return m_hit[s];
        return 0;
    endfunction

    // One clock: advance the model with the inputs about to be sampled, then compare after the edge.
    task automatic tick();
        int win; bit wdrop; bit pass; int nwin; int ecv; bit eoe;
        logic [47:0] eod; logic [3:0] eled;
        ecv   = sel_model(cnt_sel);
        win   = input_enable ? decide(input_data) : -1;
        wdrop = (win >= 0) ? m_dr[win] : 1'b0;
        pass  = p_valid && ((p_win >= 0) ? !p_wdrop : default_pass);
        eoe   = pass;
        eod   = p_rec;
        nwin  = p_valid ? p_win : -1;
        if (cnt_clear) begin
            for (int c = 0; c < CH; c++) m_hit[c] = 0;
            m_dropc = 0;
        end else begin
            if (nwin >= 0 && m_hit[nwin] < CMAX) m_hit[nwin]++;
            if (p_valid && !pass && m_dropc < CMAX) m_dropc++;
        end
        for (int c = 0; c < CH; c++) begin
            if (w_reg == c) m_led[c] = LS;
            else if (m_led[c] > 0) m_led[c]--;
        end
        w_reg = nwin;
        if (cfg_write && cfg_channel < CH) begin
            int k;
            k = int'(cfg_channel);
            m_en[k] = cfg_enable; m_dr[k] = cfg_drop;
            m_addr[k] = cfg_addr; m_am[k] = cfg_addr_mask;
            m_data[k] = cfg_data; m_dm[k] = cfg_data_mask;
            m_cyc[k] = cfg_cyc; m_cm[k] = cfg_cyc_mask;
        end
        p_valid = input_enable; p_rec = input_data; p_win = win; p_wdrop = wdrop;
        if (reset) begin
            model_reset();
            eoe = 0; eod = '0; ecv = 0;
        end
        for (int c = 0; c < CH; c++) eled[c] = (m_led[c] != 0);
        @(posedge clock);
        #1;
        check("output_enable", output_enable, eoe);
        if (eoe || reset) check("output_data", output_data, eod);
        check("trigger_led", trigger_led, eled);
        check("cnt_value", cnt_value, ecv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [47:0] r);
        input_enable = 1'b1;
        input_data   = r;
        tick();
        input_enable = 1'b0;
    endtask

    task automatic cfg_ch(input int ch, input bit en, input bit dr,
                          input logic [31:0] a, input logic [31:0] am,
                          input logic [3:0] cy, input logic [3:0] cm);
        cfg_channel = 4'(ch); cfg_enable = en; cfg_drop = dr;
        cfg_addr = a; cfg_addr_mask = am; cfg_data = '0; cfg_data_mask = '0;
        cfg_cyc = cy; cfg_cyc_mask = cm;
        cfg_write = 1'b1;
        tick();
        cfg_write = 1'b0;
    endtask

    task automatic read_cnt(input logic [4:0] s, input int exp, input string tag);
        cnt_sel = s;
        idle(2);
        check(tag, cnt_value, exp);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(4))
            0: return 32'h80;
            1: return 32'h81;
            2: return 32'h90;
            3: return 32'h3F8;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] sel_pool [7];
        logic [31:0] am_pool [3];
        sel_pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd31, 5'd17};
        am_pool  = '{32'hFFFF_FFFF, 32'hFFFF_FF00, 32'h0};
        model_reset();

        // Reset state
        reset = 1'b1;
        idle(3);
        check("reset_output_data", output_data, 48'h0);
        reset = 1'b0;
        tick();

        // No channels, default pass: everything forwarded
        default_pass = 1'b1;
        send(REC_A);
        send(48'h0000_03F8_4103);
        idle(3);
        read_cnt(5'd31, 0, "drop_after_default_pass");
        check("leds_idle", trigger_led, 4'b0000);

        // Single pass channel with default drop; LED timed by the per-cycle model
        cfg_ch(0, 1, 0, 32'h80, 32'hFFFF_FFFF, 4'b0010, 4'hF);
        default_pass = 1'b0;
        send(REC_A);
        send(REC_B);
        idle(12);
        read_cnt(5'd0, 1, "hit0_single");
        read_cnt(5'd31, 1, "drop_single");

        // Overlapping channels: lowest index wins
        cfg_ch(1, 1, 1, 32'h80, 32'hFFFF_FFFF, 4'h0, 4'h0);
        send(REC_A);
        idle(3);
        read_cnt(5'd0, 2, "hit0_overlap");
        read_cnt(5'd1, 0, "hit1_overlap");
        cfg_ch(0, 0, 0, 32'h80, 32'hFFFF_FFFF, 4'b0010, 4'hF);
        send(REC_A);
        idle(3);
        read_cnt(5'd1, 1, "hit1_ch0_off");
        read_cnt(5'd31, 2, "drop_ch0_off");

        // 16 back-to-back alternating pass/drop records
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        cfg_ch(0, 1, 0, 32'h80, 32'hFFFF_FFFF, 4'b0010, 4'hF);
        cfg_ch(1, 1, 1, 32'h90, 32'hFFFF_FFFF, 4'h0, 4'h0);
        default_pass = 1'b1;
        input_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            input_data = (i % 2 == 0) ? REC_A : REC_C;
            tick();
        end
        input_enable = 1'b0;
        idle(3);
        read_cnt(5'd0, 8, "hit0_burst16");
        read_cnt(5'd1, 8, "hit1_burst16");
        read_cnt(5'd31, 8, "drop_burst16");

        // Saturation
        input_enable = 1'b1;
        input_data   = REC_A;
        idle(20);
        input_enable = 1'b0;
        idle(3);
        read_cnt(5'd0, 15, "hit0_saturated");

        // Clear coinciding with a counted hit
        send(REC_A);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        idle(2);
        read_cnt(5'd0, 0, "clear_beats_hit");

        // Config write in the same cycle as a record's first stage
        cfg_channel = 4'd0; cfg_enable = 1'b1; cfg_drop = 1'b1;
        cfg_addr = 32'h80; cfg_addr_mask = 32'hFFFF_FFFF;
        cfg_cyc = 4'b0010; cfg_cyc_mask = 4'hF;
        cfg_write = 1'b1;
        input_enable = 1'b1;
        input_data = REC_A;
        tick();
        cfg_write = 1'b0;
        tick();
        check("old_cfg_passes", output_enable, 1'b1);
        input_enable = 1'b0;
        tick();
        check("new_cfg_drops", output_enable, 1'b0);
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            input_enable  = ($urandom_range(3) != 0);
            input_data    = {pick_addr(), (($urandom_range(2) == 0) ? 8'h34 : 8'($urandom)), 4'h0, 4'($urandom_range(7))};
            cfg_write     = ($urandom_range(5) == 0);
            cfg_channel   = 4'($urandom_range(7));
            cfg_enable    = ($urandom_range(3) != 0);
            cfg_drop      = 1'($urandom);
            cfg_addr      = pick_addr();
            cfg_addr_mask = am_pool[$urandom_range(2)];
            cfg_data      = 8'h34;
            cfg_data_mask = ($urandom_range(1) == 0) ? 8'hFF : 8'h00;
            cfg_cyc       = 4'($urandom_range(7));
            cfg_cyc_mask  = ($urandom_range(1) == 0) ? 4'hF : 4'h0;
            if (i % 16 == 0) default_pass = 1'($urandom);
            cnt_clear     = ($urandom_range(31) == 0);
            cnt_sel       = sel_pool[$urandom_range(6)];
            tick();
        end
        input_enable = 1'b0; cfg_write = 1'b0; cnt_clear = 1'b0;
        idle(2);

        // Reset with records in both pipeline stages
        for (int c = 0; c < CH; c++) cfg_ch(c, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0);
        default_pass = 1'b1;
        cfg_ch(2, 1, 0, 32'h80, 32'hFFFF_FFFF, 4'h0, 4'h0);
        input_enable = 1'b1;
        input_data = REC_A;
        tick();
        tick();
        input_enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("no_oe_after_reset", output_enable, 1'b0);
        check("leds_after_reset", trigger_led, 4'b0000);
        idle(2);
        read_cnt(5'd2, 0, "hit2_after_reset");
        default_pass = 1'b0;
        send(REC_A);
        idle(3);
        read_cnt(5'd31, 1, "channels_disabled_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
